// File: rtl/step_if.sv
// step_if: step offer/consume handshake between the scheduler and the downstream FSM.
interface step_if;
   logic       step_req;
   logic       step_src;
   logic       step_ack;
   logic [1:0] pending;
   logic       ovf;
   modport master(output step_req, step_src, pending, ovf, input step_ack);
   modport slave(input step_req, step_src, pending, ovf, output step_ack);
endinterface

// File: rtl/step_scheduler.sv
// step_scheduler: merges rotary manual steps (queued) and periodic auto ticks into a paced step offer.
module step_scheduler #(
   parameter int TICK_CYCLES = 100000000,
   parameter int QMAX        = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rot_event,
   input  logic       auto_en,
   input  logic [1:0] rate_sel,
   input  logic       clr_ovf,
   step_if.master     s
);
   localparam int TW = $clog2(TICK_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
   state_t state, state_n;
   logic src, src_n, prev, auto_pend, ovf;
   logic [1:0] pending;
   logic [TW-1:0] timer, period;
   logic tick, edge_m, ack_m, ack_a, drop;
   assign period = TW'(TICK_CYCLES >> rate_sel);
   // >= rather than == so shrinking the period mid-count still wraps next cycle
   assign tick   = auto_en && (timer >= period - 1'b1);
   assign edge_m = rot_event & ~prev;
   assign ack_m  = (state == REQ) && s.step_ack && src;
   assign ack_a  = (state == REQ) && s.step_ack && !src;
   assign drop   = (edge_m && !ack_m && pending == 2'(QMAX)) || (tick && auto_pend && !ack_a);
   assign s.step_req = (state == REQ);
   assign s.step_src = src;
   assign s.pending  = pending;
   assign s.ovf      = ovf;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         src       <= 1'b0;
         prev      <= 1'b1;
         auto_pend <= 1'b0;
         timer     <= '0;
         pending   <= 2'd0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_n;
         src       <= src_n;
         prev      <= rot_event;
         timer     <= (tick || !auto_en) ? '0 : timer + 1'b1;
         auto_pend <= tick || (auto_pend && !ack_a);
         pending   <= (edge_m && !ack_m && pending != 2'(QMAX)) ? pending + 2'd1 :
                      (ack_m && !edge_m) ? pending - 2'd1 : pending;
         ovf       <= drop || (ovf && !clr_ovf);
      end
   end
   always_comb begin
      state_n = state;
      src_n   = src;
      if (state == IDLE && (pending != 2'd0 || auto_pend)) begin
         state_n = REQ;
         src_n   = (pending != 2'd0);
      end else if (state == REQ && s.step_ack) state_n = GAP;
      else if (state == GAP) state_n = IDLE;
   end
endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler: directed stimulus with a source-order scoreboard on accepted steps.
module tb_step_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rot_event = 1'b1;
   logic auto_en = 1'b0;
   logic [1:0] rate_sel = 2'd0;
   logic clr_ovf = 1'b0;
   int errors = 0;
   int checks = 0;
   bit exp_q[$];
   step_if s();
   step_scheduler #(.TICK_CYCLES(8), .QMAX(3)) dut (
      .clk(clk), .rst_n(rst_n), .rot_event(rot_event), .auto_en(auto_en),
      .rate_sel(rate_sel), .clr_ovf(clr_ovf), .s(s.master)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic rise();
      rot_event = 1'b0;
      cyc(1);
      rot_event = 1'b1;
      cyc(1);
   endtask
   // every accepted step is checked against the expected source order
   always @(negedge clk) begin
      if (rst_n && s.step_req && s.step_ack) begin
         if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
         else chk("step_src", int'(s.step_src), int'(exp_q.pop_front()));
      end
   end
   initial begin
      s.step_ack = 1'b0;
      cyc(2);
      chk("rst_req", s.step_req, 0);
      chk("rst_src", s.step_src, 0);
      chk("rst_pending", s.pending, 0);
      chk("rst_ovf", s.ovf, 0);
      rst_n = 1'b1;
      cyc(5);
      chk("held_high_no_step", s.step_req, 0);
      chk("held_high_pending", s.pending, 0);
      rot_event = 1'b0;
      cyc(1);
      rot_event = 1'b1;
      cyc(1);
      chk("edge_pending", s.pending, 1);
      chk("edge_req_not_yet", s.step_req, 0);
      cyc(1);
      chk("edge_req", s.step_req, 1);
      chk("edge_src", s.step_src, 1);
      exp_q.push_back(1'b1);
      s.step_ack = 1'b1;
      cyc(1);
      s.step_ack = 1'b0;
      chk("after_ack_req", s.step_req, 0);
      chk("after_ack_pending", s.pending, 0);
      repeat (4) rise();
      chk("q_full_pending", s.pending, 3);
      chk("q_full_ovf", s.ovf, 1);
      chk("q_full_req", s.step_req, 1);
      repeat (3) exp_q.push_back(1'b1);
      s.step_ack = 1'b1;
      cyc(12);
      s.step_ack = 1'b0;
      chk("drain_pending", s.pending, 0);
      chk("drain_req", s.step_req, 0);
      chk("ovf_sticky", s.ovf, 1);
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      chk("ovf_cleared", s.ovf, 0);
      repeat (3) rise();
      chk("refill_pending", s.pending, 3);
      rot_event = 1'b0;
      cyc(1);
      rot_event = 1'b1;
      exp_q.push_back(1'b1);
      s.step_ack = 1'b1;
      cyc(1);
      s.step_ack = 1'b0;
      chk("edge_ack_pending", s.pending, 3);
      chk("edge_ack_ovf", s.ovf, 0);
      repeat (3) exp_q.push_back(1'b1);
      s.step_ack = 1'b1;
      cyc(12);
      s.step_ack = 1'b0;
      chk("drain2_pending", s.pending, 0);
      rot_event = 1'b0;
      auto_en = 1'b1;
      cyc(7);
      rot_event = 1'b1;
      cyc(1);
      auto_en = 1'b0;
      chk("tie_pending", s.pending, 1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      s.step_ack = 1'b1;
      cyc(1);
      chk("tie_first_req", s.step_req, 1);
      chk("tie_first_src", s.step_src, 1);
      cyc(3);
      chk("tie_second_req", s.step_req, 1);
      chk("tie_second_src", s.step_src, 0);
      cyc(1);
      s.step_ack = 1'b0;
      chk("tie_done_req", s.step_req, 0);
      chk("tie_ovf", s.ovf, 0);
      repeat (3) exp_q.push_back(1'b0);
      auto_en = 1'b1;
      s.step_ack = 1'b1;
      cyc(9);
      chk("auto1_req", s.step_req, 1);
      chk("auto1_src", s.step_src, 0);
      cyc(1);
      chk("auto_gap", s.step_req, 0);
      cyc(7);
      chk("auto2_req", s.step_req, 1);
      cyc(8);
      chk("auto3_req", s.step_req, 1);
      auto_en = 1'b0;
      cyc(1);
      s.step_ack = 1'b0;
      cyc(2);
      chk("auto_stop_req", s.step_req, 0);
      auto_en = 1'b1;
      cyc(6);
      rate_sel = 2'd2;
      cyc(1);
      chk("rate_no_req_yet", s.step_req, 0);
      cyc(1);
      chk("rate_wrap_req", s.step_req, 1);
      chk("rate_wrap_ovf", s.ovf, 0);
      cyc(1);
      chk("rate_period2_ovf", s.ovf, 1);
      auto_en = 1'b0;
      cyc(3);
      chk("auto_off_hold_req", s.step_req, 1);
      chk("auto_off_hold_src", s.step_src, 0);
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      chk("ovf_clr2", s.ovf, 0);
      exp_q.push_back(1'b0);
      s.step_ack = 1'b1;
      cyc(1);
      s.step_ack = 1'b0;
      cyc(2);
      chk("auto_off_done", s.step_req, 0);
      auto_en = 1'b1;
      cyc(3);
      exp_q.push_back(1'b0);
      exp_q.push_back(1'b0);
      s.step_ack = 1'b1;
      cyc(1);
      s.step_ack = 1'b0;
      auto_en = 1'b0;
      cyc(2);
      chk("tick_ack_req", s.step_req, 1);
      chk("tick_ack_src", s.step_src, 0);
      chk("tick_ack_ovf", s.ovf, 0);
      s.step_ack = 1'b1;
      cyc(1);
      s.step_ack = 1'b0;
      rate_sel = 2'd0;
      cyc(3);
      chk("tick_ack_idle", s.step_req, 0);
      rise();
      rise();
      chk("mid_req", s.step_req, 1);
      chk("mid_pending", s.pending, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("async_req", s.step_req, 0);
      chk("async_pending", s.pending, 0);
      cyc(1);
      chk("rst2_src", s.step_src, 0);
      chk("rst2_ovf", s.ovf, 0);
      rst_n = 1'b1;
      cyc(3);
      chk("post_rst_req", s.step_req, 0);
      chk("post_rst_pending", s.pending, 0);
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
